dmem_arbiter: RTL and testbench

Shares the single-port data memory between the two cores of the dual-core CPU. Each core's MEM stage presents at most one load or store at a time. The block grants one core, runs a ready-handshaked transaction on the memory port, and returns a one-cycle acknowledge with captured read data. The ungranted core stalls until served, and round-robin priority prevents starvation.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dual-core data memory arbiter:
// FSM state encoding and core identifiers.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. On a conflict the core named by prio wins;
// otherwise whichever core is requesting is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic grant_valid,
  output logic grant_id
);

  // Select the winning core from the current requests and priority
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = CORE0;
    if (req0 && req1) begin
      grant_id = prio;
    end else if (req1) begin
      grant_id = CORE1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two cores. A granted core's
// request is copied into registered memory-port outputs, held until the
// memory signals ready, then acknowledged with a one-cycle pulse. Load data
// is captured per core and held until that core's next load completes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          stall1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_t state;
  logic   grant;
  logic   prio;
  logic   grant_valid;
  logic   grant_id;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .prio        (prio),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Stall a core while its request is outstanding and not yet acknowledged
  always_comb begin
    stall0 = req0 & ~ack0;
    stall1 = req1 & ~ack1;
  end

  // Arbitration FSM: grant in IDLE, wait for ready in BUSY, ack in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      grant     <= CORE0;
      prio      <= CORE0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      // Acks are single-cycle pulses; only the BUSY exit raises one
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            grant   <= grant_id;
            mem_req <= 1'b1;
            if (grant_id == CORE1) begin
              mem_we    <= we1;
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
            end else begin
              mem_we    <= we0;
              mem_addr  <= addr0;
              mem_wdata <= wdata0;
            end
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Memory-port fields stay frozen until the memory completes
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (grant == CORE1) begin
              ack1 <= 1'b1;
              if (!mem_we) rdata1 <= mem_rdata;
            end else begin
              ack0 <= 1'b1;
              if (!mem_we) rdata0 <= mem_rdata;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The acked core's request is still high here, so it is not
          // sampled; the other core gets priority next time.
          prio  <= ~grant;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ack0, ack1, stall0, stall1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .rdata0    (rdata0),
    .ack0      (ack0),
    .stall0    (stall0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .rdata1    (rdata1),
    .ack1      (ack1),
    .stall1    (stall1),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #3;
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_core;
    rst_i = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 0;

    // Reset values
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    step();
    rst_i = 1'b0;
    step();

    // Single load by core 0
    req0 = 1; we0 = 0; addr0 = 32'h10;
    #1;
    chk("ld_stall0_c0", stall0, 1);
    chk("ld_memreq_c0", mem_req, 0);
    step();
    chk("ld_memreq_c1", mem_req, 1);
    chk("ld_memaddr_c1", mem_addr, 32'h10);
    chk("ld_memwe_c1", mem_we, 0);
    chk("ld_stall0_c1", stall0, 1);
    chk("ld_ack0_c1", ack0, 0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ready = 0;
    chk("ld_ack0_c2", ack0, 1);
    chk("ld_ack1_c2", ack1, 0);
    chk("ld_rdata0_c2", rdata0, 32'hDEADBEEF);
    chk("ld_stall0_c2", stall0, 0);
    chk("ld_memreq_c2", mem_req, 0);
    req0 = 0;
    step();
    chk("ld_ack0_c3", ack0, 0);

    // Conflict after reset: prio=0 so core 0 first
    do_reset();
    step();
    req0 = 1; we0 = 0; addr0 = 32'h100;
    req1 = 1; we1 = 0; addr1 = 32'h104;
    #1;
    chk("cf_stall1_c0", stall1, 1);
    step();
    chk("cf_first_addr", mem_addr, 32'h100);
    mem_ready = 1; mem_rdata = 32'hA0A0A0A0;
    step();
    mem_ready = 0;
    chk("cf_ack0", ack0, 1);
    chk("cf_ack1_low", ack1, 0);
    chk("cf_rdata0", rdata0, 32'hA0A0A0A0);
    chk("cf_stall1_done", stall1, 1);
    req0 = 0;
    step();
    // Core 0 re-requests while core 1 still waits: prio=1 now favours core 1
    req0 = 1; addr0 = 32'h108;
    #1;
    chk("cf_stall0_idle", stall0, 1);
    step();
    chk("cf_prio1_addr", mem_addr, 32'h104);
    chk("cf_prio1_req", mem_req, 1);
    mem_ready = 1; mem_rdata = 32'hB1B1B1B1;
    step();
    mem_ready = 0;
    chk("cf_ack1", ack1, 1);
    chk("cf_ack0_low", ack0, 0);
    chk("cf_rdata1", rdata1, 32'hB1B1B1B1);
    chk("cf_stall0_wait", stall0, 1);
    req1 = 0;
    step();
    step();
    chk("cf_third_addr", mem_addr, 32'h108);
    mem_ready = 1; mem_rdata = 32'hC2C2C2C2;
    step();
    mem_ready = 0;
    chk("cf_ack0_third", ack0, 1);
    chk("cf_rdata0_third", rdata0, 32'hC2C2C2C2);
    req0 = 0;
    step();

    // Store by core 1 with three wait cycles
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("st_memreq", mem_req, 1);
      chk("st_memwe", mem_we, 1);
      chk("st_memaddr", mem_addr, 32'h20);
      chk("st_memwdata", mem_wdata, 32'h12345678);
      chk("st_ack1_wait", ack1, 0);
      if (i < 3) step();
    end
    mem_ready = 1; mem_rdata = 32'hEEEEEEEE;
    step();
    mem_ready = 0;
    chk("st_ack1", ack1, 1);
    chk("st_rdata1_kept", rdata1, 32'hB1B1B1B1);
    req1 = 0; we1 = 0;
    step();
    chk("st_ack1_off", ack1, 0);

    // Spurious mem_ready while idle
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    step();
    chk("sp_memreq", mem_req, 0);
    chk("sp_ack0", ack0, 0);
    chk("sp_ack1", ack1, 0);
    chk("sp_rdata0", rdata0, 32'hC2C2C2C2);
    mem_ready = 0;

    // Reset mid-BUSY
    req0 = 1; we0 = 0; addr0 = 32'h44;
    step();
    chk("rb_memreq_busy", mem_req, 1);
    rst_i = 1;
    #1;
    chk("rb_memreq", mem_req, 0);
    chk("rb_memaddr", mem_addr, 0);
    chk("rb_rdata0", rdata0, 0);
    chk("rb_rdata1", rdata1, 0);
    chk("rb_ack0", ack0, 0);
    step();
    chk("rb_ack0_hold", ack0, 0);
    rst_i = 0;
    step();
    chk("rb_new_req", mem_req, 1);
    chk("rb_new_addr", mem_addr, 32'h44);
    mem_ready = 1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ready = 0;
    chk("rb_new_ack0", ack0, 1);
    chk("rb_new_rdata0", rdata0, 32'h55AA55AA);
    req0 = 0;
    step();

    // Starvation: both cores request continuously; grants alternate
    do_reset();
    step();
    req0 = 1; we0 = 0; addr0 = 32'h300;
    req1 = 1; we1 = 0; addr1 = 32'h400;
    exp_core = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      chk("sv_addr", mem_addr, exp_core ? 32'h400 : 32'h300);
      mem_ready = 1; mem_rdata = 32'h1000 + t;
      step();
      mem_ready = 0;
      chk("sv_ack0", ack0, {31'd0, ~exp_core});
      chk("sv_ack1", ack1, {31'd0, exp_core});
      exp_core = ~exp_core;
      step();
    end
    req0 = 0; req1 = 0;
    step();
    chk("sv_idle", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
